ni_resend_transaction_fifo: RTL
===============================

// Module: ni_resend_transaction_fifo
// PURPOSE
//  Multi-entry, in-order store of per-transaction response info (read/write type, ID, source) for the NI target.
//  Successor to the single-register store: it holds up to DEPTH outstanding transactions instead of one.
//  Each entry is captured when a request is accepted and retired when its response packet has been sent.
//  Head fields are presented to the response packetizer, with optional same-cycle bypass when the store is empty.
// PARAMETERS
//  ID_WD   8  width of transaction ID field
//  SRC_WD  5  width of message source (NoC address) field
//  DEPTH   4  number of entries; power of 2, >=2
//  CNT_WD  $clog2(DEPTH)+1  occupancy counter width (localparam, not overridable)
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset, synchronous, active-high
//  push_valid    in   1       new transaction info presented
//  push_ready    out  1       store can accept; = !full
//  push_is_read  in   1       1 = read transaction, 0 = write
//  push_id       in   ID_WD   transaction ID
//  push_source   in   SRC_WD  requesting source
//  pop_valid     out  1       head entry valid
//  pop_ready     in   1       packetizer retires head this cycle
//  head_is_read  out  1       head packet type
//  head_id       out  ID_WD   head transaction ID
//  head_source   out  SRC_WD  head message source
//  count         out  CNT_WD  entries stored (bypassed entries excluded)
//  err_overflow  out  1       sticky: push_valid seen while !push_ready
// BEHAVIOUR
//  - Reset (sync):
//    - wr_ptr, rd_ptr, count, err_overflow -> 0.
//    - pop_valid, push_ready outputs -> 0 and 1.
//    - head_* outputs -> 0.
//    - Storage array is not reset.
//  - Push fires on push_valid & push_ready. The entry is written at wr_ptr; wr_ptr increments mod DEPTH.
//  - Pop fires on pop_valid & pop_ready. rd_ptr increments mod DEPTH.
//  - Pop with !pop_valid is ignored; no state change.
//  - Simultaneous push and pop with count>0: both fire, count unchanged, pointers both advance.
//  - Full (count==DEPTH): push_ready=0.
//    - No pass-through: a same-cycle pop does not make room until the next cycle.
//  - Overflow: push_valid & !push_ready -> data dropped, err_overflow set; cleared only by rst.
//  - Head outputs when count>0 = array[rd_ptr]; pop_valid=1.
//  - Head outputs when count==0 and no bypass path: head_* = 0, pop_valid=0.
//  - Pointer wrap: at DEPTH-1 the next value is 0. count is the sole full/empty source.
//  - Latency without bypass: pushed entry visible on head the cycle after the push.
//  - Head outputs are stable while pop_valid & !pop_ready.
// CONFIGURATION
//  NI_RESEND_TXN_FIFO_BYPASS_EN defined:
//   - When count==0 & push_valid: pop_valid=1 and head_* = push_* combinationally (same cycle).
//   - If pop_ready is also 1, the entry is consumed directly: no write, count stays 0, pointers unchanged.
//   - If pop_ready is 0, the entry is written normally and appears from storage next cycle.
//  NI_RESEND_TXN_FIFO_BYPASS_EN undefined:
//   - No combinational path from push_* to pop_valid or head_*.
//   - Minimum push-to-head latency is 1 cycle.
// TESTING
//  1. rst=1 for 2 cycles -> count=0, pop_valid=0, push_ready=1, err_overflow=0, head_*=0.
//  2. Push (1,0x11,3),(0,0x22,4),(1,0x33,5), then pop_ready=1 -> heads in order 0x11,0x22,0x33, types 1/0/1; count 3->0.
//  3. DEPTH=4: push 5 entries back-to-back, pop_ready=0 -> push_ready=0 after the 4th push.
//     The 5th push is dropped, err_overflow=1, count=4, and the head stays at the first entry.
//  4. Full, then push+pop same cycle -> pop fires, push blocked; next cycle push_ready=1, count=3.
//  5. Wrap check: 10 push/pop pairs with count held at 2 -> IDs return in order across the pointer wrap; count stays 2.
//  6. BYPASS_EN: empty, push 0x5A with pop_ready=1 -> head_id=0x5A and pop_valid=1 same cycle, count stays 0.
//     Without BYPASS_EN: pop_valid=0 that cycle, 1 the next.
//  7. Reset with count=3 -> next cycle count=0, pop_valid=0; a subsequent push then pop returns the new entry only.

Source files
------------

// File: rtl/ni_resend_transaction_fifo.sv
// In-order store of per-transaction response info (type, ID, source) for the NI target.
// Optional same-cycle bypass when empty is enabled by defining NI_RESEND_TXN_FIFO_BYPASS_EN.
module ni_resend_transaction_fifo #(
  parameter int ID_WD  = 8,
  parameter int SRC_WD = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic                     push_is_read,
  input  logic [ID_WD-1:0]         push_id,
  input  logic [SRC_WD-1:0]        push_source,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic                     head_is_read,
  output logic [ID_WD-1:0]         head_id,
  output logic [SRC_WD-1:0]        head_source,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_overflow
);

  localparam int CNT_WD   = $clog2(DEPTH) + 1;
  localparam int PTR_WD   = $clog2(DEPTH);
  localparam int ENTRY_WD = 1 + ID_WD + SRC_WD;

  logic [ENTRY_WD-1:0] mem [DEPTH];
  logic [PTR_WD-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_WD-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CNT_WD-1:0]   count_reg, count_next;
  logic                err_overflow_reg;

  logic                empty;
  logic                full;
  logic                bypass_take;
  logic                push_fire;
  logic                pop_fire;
  logic [ENTRY_WD-1:0] push_entry;
  logic [ENTRY_WD-1:0] head_entry;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CNT_WD'(DEPTH));
  assign push_entry = {push_is_read, push_id, push_source};

`ifdef NI_RESEND_TXN_FIFO_BYPASS_EN
  // Empty store with a ready consumer: the entry goes straight through and is never written.
  assign bypass_take = empty & push_valid & pop_ready;
`else
  assign bypass_take = 1'b0;
`endif

  assign push_fire = push_valid & ~full & ~bypass_take;
  assign pop_fire  = ~empty & pop_ready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_fire) begin
      wr_ptr_next = (wr_ptr_reg == PTR_WD'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop_fire) begin
      rd_ptr_next = (rd_ptr_reg == PTR_WD'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
    end
    unique case ({push_fire, pop_fire})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      err_overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (push_valid & full) begin
        err_overflow_reg <= 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_comb begin
    head_entry = '0;
    pop_valid  = 1'b0;
    if (!empty) begin
      head_entry = mem[rd_ptr_reg];
      pop_valid  = 1'b1;
    end
`ifdef NI_RESEND_TXN_FIFO_BYPASS_EN
    else if (push_valid) begin
      head_entry = push_entry;
      pop_valid  = 1'b1;
    end
`endif
  end

  assign {head_is_read, head_id, head_source} = head_entry;
  assign push_ready   = ~full;
  assign count        = count_reg;
  assign err_overflow = err_overflow_reg;

endmodule
